// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if: event inputs and audio/status outputs of the sound-effect
// sequencer, bundled so the game logic and the sequencer share one port.
interface sfx_sequencer_if;
   logic       hit;         // single-cycle pulse: ball hit a wall or paddle
   logic       score_evt;   // single-cycle pulse: a point was scored
   logic       score_side;  // 0 = ascending jingle, 1 = descending jingle
   logic       mute;        // level: silence the speaker, keep sequencing
   logic       pmod_1;      // square-wave audio
   logic       pmod_2;      // amplifier gain select
   logic       pmod_4;      // amplifier shutdown_n
   logic       busy;        // a sound is in progress
   logic [1:0] note_idx;    // current score note

   // Game-side view: raises events, observes the audio and status lines.
   modport master (
      output hit, score_evt, score_side, mute,
      input  pmod_1, pmod_2, pmod_4, busy, note_idx
   );

   // Sequencer-side view.
   modport slave (
      input  hit, score_evt, score_side, mute,
      output pmod_1, pmod_2, pmod_4, busy, note_idx
   );
endinterface

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays a short hit tone on paddle/wall collisions and a
// three-note jingle (ascending or descending) when a point is scored.
// Every output is taken straight from a flop, so events show up one cycle
// after their input pulse.
module sfx_sequencer #(
   parameter int unsigned HIT_HP   = 113636,     // 440 Hz at 100 MHz
   parameter int unsigned NOTE1_HP = 56818,      // 880 Hz
   parameter int unsigned NOTE2_HP = 47778,      // 1046 Hz
   parameter int unsigned NOTE3_HP = 37921,      // 1318 Hz
   parameter int unsigned HIT_CYC  = 5_000_000,  // hit tone length
   parameter int unsigned NOTE_CYC = 10_000_000, // length of each score note
   parameter int unsigned GAP_CYC  = 2_000_000   // silence between notes
) (
   input logic            clk,
   input logic            rst,   // asynchronous, active-low
   sfx_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef enum logic {
      MODE_HIT   = 1'b0,
      MODE_SCORE = 1'b1
   } mode_t;

   // Terminal counts, pre-sized to the counter widths.
   localparam logic [23:0] HIT_LAST  = 24'(HIT_CYC - 1);
   localparam logic [23:0] NOTE_LAST = 24'(NOTE_CYC - 1);
   localparam logic [23:0] GAP_LAST  = 24'(GAP_CYC - 1);
   localparam logic [16:0] HP_HIT    = 17'(HIT_HP);
   localparam logic [16:0] HP_NOTE1  = 17'(NOTE1_HP);
   localparam logic [16:0] HP_NOTE2  = 17'(NOTE2_HP);
   localparam logic [16:0] HP_NOTE3  = 17'(NOTE3_HP);

   state_t      state;
   mode_t       mode;
   logic        dir;        // latched score_side of the running jingle
   logic [1:0]  note_idx;
   logic [23:0] dur;        // cycles spent in the current PLAY or GAP
   logic [16:0] ph;         // position within the current half-period
   logic        tone;       // unmuted square wave
   logic        pmod_1;
   logic        pmod_4;
   logic        busy;

   logic [1:0]  pitch;      // note_idx folded through the jingle direction
   logic [16:0] hp;         // half-period of whatever is playing
   logic        play_last;  // final cycle of the current tone or note
   logic        gap_last;   // final cycle of the current gap
   logic        ph_last;    // final cycle of the current half-period

   // Pick the half-period and flag the terminal count of each counter.
   always_comb begin
      // NOTE: every variable written here gets a value before any branch,
      // otherwise synthesis infers a latch to hold it on untaken paths.
      pitch = dir ? (2'd2 - note_idx) : note_idx;
      hp    = HP_HIT;
      if (mode == MODE_SCORE) begin
         case (pitch)
            2'd0:    hp = HP_NOTE1;
            2'd1:    hp = HP_NOTE2;
            default: hp = HP_NOTE3;
         endcase
      end
      play_last = (dur == ((mode == MODE_HIT) ? HIT_LAST : NOTE_LAST));
      gap_last  = (dur == GAP_LAST);
      ph_last   = (ph == (hp - 17'd1));
   end

   // Sequencer FSM with registered outputs: event handling, note/gap timing
   // and square-wave generation.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: only control and counter flops live here; they all need a
      // known value because the FSM decodes them straight out of reset.
      if (!rst) begin
         state    <= IDLE;
         mode     <= MODE_HIT;
         dir      <= 1'b0;
         note_idx <= 2'd0;
         dur      <= 24'd0;
         ph       <= 17'd0;
         tone     <= 1'b0;
         pmod_1   <= 1'b0;
         pmod_4   <= 1'b0;
         busy     <= 1'b0;
      end else if (bus.score_evt) begin
         // A score always (re)starts the jingle and swallows a coincident hit.
         // NOTE: non-blocking assignments, so every branch reads the
         // pre-edge values of the state and counters.
         state    <= PLAY;
         mode     <= MODE_SCORE;
         dir      <= bus.score_side;
         note_idx <= 2'd0;
         dur      <= 24'd0;
         ph       <= 17'd0;
         tone     <= 1'b0;
         pmod_1   <= 1'b0;
         pmod_4   <= 1'b1;
         busy     <= 1'b1;
      end else if (bus.hit && (state == IDLE || (state == PLAY && mode == MODE_HIT))) begin
         // A hit starts the tone from idle or restarts a running hit tone;
         // it never interrupts a jingle.
         state    <= PLAY;
         mode     <= MODE_HIT;
         note_idx <= 2'd0;
         dur      <= 24'd0;
         ph       <= 17'd0;
         tone     <= 1'b0;
         pmod_1   <= 1'b0;
         pmod_4   <= 1'b1;
         busy     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               pmod_1 <= 1'b0;
            end

            PLAY: begin
               if (play_last) begin
                  dur    <= 24'd0;
                  ph     <= 17'd0;
                  tone   <= 1'b0;
                  pmod_1 <= 1'b0;
                  if (mode == MODE_SCORE && note_idx != 2'd2) begin
                     state <= GAP;
                  end else begin
                     state    <= IDLE;
                     note_idx <= 2'd0;
                     pmod_4   <= 1'b0;
                     busy     <= 1'b0;
                  end
               end else begin
                  dur <= dur + 24'd1;
                  if (ph_last) begin
                     ph     <= 17'd0;
                     tone   <= ~tone;
                     pmod_1 <= ~tone & ~bus.mute;
                  end else begin
                     ph     <= ph + 17'd1;
                     pmod_1 <= tone & ~bus.mute;
                  end
               end
            end

            GAP: begin
               pmod_1 <= 1'b0;
               if (gap_last) begin
                  state    <= PLAY;
                  note_idx <= note_idx + 2'd1;
                  dur      <= 24'd0;
                  ph       <= 17'd0;
                  tone     <= 1'b0;
               end else begin
                  dur <= dur + 24'd1;
               end
            end

            default: begin
               // Unused encoding: fall back to a silent idle.
               state    <= IDLE;
               note_idx <= 2'd0;
               dur      <= 24'd0;
               ph       <= 17'd0;
               tone     <= 1'b0;
               pmod_1   <= 1'b0;
               pmod_4   <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pmod_1   = pmod_1;
   assign bus.pmod_2   = 1'b1;   // gain select is tied high, even in reset
   assign bus.pmod_4   = pmod_4;
   assign bus.busy     = busy;
   assign bus.note_idx = note_idx;

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: self-checking bench for sfx_sequencer with short
// simulation timings. Expected outputs come from a hand-written vector table
// and from a model that derives the sound from the time elapsed since the
// triggering event.
module tb_sfx_sequencer;

   localparam int HIT_HP    = 5;
   localparam int NOTE1_HP  = 2;
   localparam int NOTE2_HP  = 3;
   localparam int NOTE3_HP  = 4;
   localparam int HIT_CYC   = 10;
   localparam int NOTE_CYC  = 20;
   localparam int GAP_CYC   = 4;
   localparam int SLOT      = NOTE_CYC + GAP_CYC;
   localparam int SCORE_LEN = 3 * NOTE_CYC + 2 * GAP_CYC;

   localparam logic [7:0] RESET_VEC = 8'b0000_0001;  // only pmod_2 high

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   sfx_sequencer_if bus ();

   sfx_sequencer #(
      .HIT_HP  (HIT_HP),
      .NOTE1_HP(NOTE1_HP),
      .NOTE2_HP(NOTE2_HP),
      .NOTE3_HP(NOTE3_HP),
      .HIT_CYC (HIT_CYC),
      .NOTE_CYC(NOTE_CYC),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp    = 0;
   int n_fail   = 0;
   int busy_cnt = 0;

   // Reference model: which sound is running and how long it has run.
   bit m_active;
   bit m_score;
   bit m_dir;
   bit m_mute;
   int m_t;

   typedef struct {
      logic       hit;
      logic       score_evt;
      logic       side;
      logic       mute;
      logic       busy;
      logic       pmod_4;
      logic [1:0] note_idx;
      logic       pmod_1;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // {2'b0, busy, pmod_4, note_idx, pmod_1, pmod_2}
   function automatic logic [7:0] dut_out();
      return {2'b00, bus.busy, bus.pmod_4, bus.note_idx, bus.pmod_1, bus.pmod_2};
   endfunction

   function automatic int note_hp(bit dir, int k);
      int asc[3] = '{NOTE1_HP, NOTE2_HP, NOTE3_HP};
      return dir ? asc[2 - k] : asc[k];
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_score  = 1'b0;
      m_dir    = 1'b0;
      m_mute   = 1'b0;
      m_t      = 0;
   endtask

   // One clock edge seen by the model with the inputs present at that edge.
   task automatic model_edge(input bit h, input bit s, input bit side, input bit m);
      if (s) begin
         m_active = 1'b1;
         m_score  = 1'b1;
         m_dir    = side;
         m_t      = 0;
      end else if (h && (!m_active || !m_score)) begin
         m_active = 1'b1;
         m_score  = 1'b0;
         m_t      = 0;
      end else if (m_active) begin
         m_t++;
         if (m_t >= (m_score ? SCORE_LEN : HIT_CYC)) m_active = 1'b0;
      end
      m_mute = m;
   endtask

   // Jingle time splits into 24-cycle slots: 20 cycles of note, 4 of gap.
   // A square wave that starts low is high during odd half-periods.
   function automatic logic [7:0] model_out();
      logic [1:0] idx;
      logic       p1;
      int         k;
      int         u;
      idx = 2'd0;
      p1  = 1'b0;
      if (m_active) begin
         if (m_score) begin
            k   = m_t / SLOT;
            u   = m_t % SLOT;
            idx = 2'(k);
            if (u < NOTE_CYC) p1 = (((u / note_hp(m_dir, k)) % 2) == 1) && !m_mute;
         end else begin
            p1 = (((m_t / HIT_HP) % 2) == 1) && !m_mute;
         end
      end
      return {2'b00, m_active, m_active, idx, p1, 1'b1};
   endfunction

   // Drive inputs for one cycle, advance the model, compare just after the edge.
   task automatic step(input string name, input bit h, input bit s, input bit side, input bit m);
      bus.hit        = h;
      bus.score_evt  = s;
      bus.score_side = side;
      bus.mute       = m;
      @(posedge clk);
      model_edge(h, s, side, m);
      #1;
      check(name, 32'(dut_out()), 32'(model_out()));
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      bus.hit       = 1'b0;
      bus.score_evt = 1'b0;
   endtask

   // Idle cycles until the sequencer goes quiet, bounded by a cycle budget.
   task automatic drain(input string name, input bit m, input int budget);
      int n = 0;
      while (bus.busy && n < budget) begin
         step(name, 1'b0, 1'b0, 1'b0, m);
         n++;
      end
      if (bus.busy) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
      end
   endtask

   initial begin
      bit mute_r;

      // Single hit pulse, then the tone runs out. Row i is the state after
      // edge i; edge 0 samples the pulse.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

      bus.hit        = 1'b0;
      bus.score_evt  = 1'b0;
      bus.score_side = 1'b0;
      bus.mute       = 1'b0;
      model_reset();

      // Reset state, and events during reset must be dropped.
      #12;
      check("reset_state", 32'(dut_out()), 32'(RESET_VEC));
      bus.hit = 1'b1;
      @(posedge clk);
      #1;
      check("reset_hit_dropped", 32'(dut_out()), 32'(RESET_VEC));
      @(negedge clk);
      bus.hit = 1'b0;
      rst     = 1'b1;
      step("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // Table-driven hit tone.
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         bus.hit        = tbl[i].hit;
         bus.score_evt  = tbl[i].score_evt;
         bus.score_side = tbl[i].side;
         bus.mute       = tbl[i].mute;
         @(posedge clk);
         model_edge(tbl[i].hit, tbl[i].score_evt, tbl[i].side, tbl[i].mute);
         #1;
         check($sformatf("hit_tbl%0d", i), 32'(dut_out()),
               32'({2'b00, tbl[i].busy, tbl[i].pmod_4, tbl[i].note_idx, tbl[i].pmod_1, 1'b1}));
         if (bus.busy) busy_cnt++;
         @(negedge clk);
         bus.hit = 1'b0;
      end
      check("hit_busy_len", busy_cnt, 10);

      // Ascending jingle.
      busy_cnt = 0;
      step("asc", 1'b0, 1'b1, 1'b0, 1'b0);
      drain("asc", 1'b0, 200);
      check("asc_busy_len", busy_cnt, SCORE_LEN);

      // Descending jingle with hits sprinkled through notes and gaps.
      busy_cnt = 0;
      step("desc", 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < SCORE_LEN; i++) step("desc_hits", (i % 3) == 0, 1'b0, 1'b0, 1'b0);
      drain("desc", 1'b0, 20);
      check("desc_busy_len", busy_cnt, SCORE_LEN);

      // hit and score_evt together: the jingle wins.
      busy_cnt = 0;
      step("hit_and_score", 1'b1, 1'b1, 1'b0, 1'b0);
      check("hit_and_score_idx_mode", {31'd0, bus.busy}, 32'd1);
      drain("hit_and_score", 1'b0, 200);
      check("hit_and_score_len", busy_cnt, SCORE_LEN);

      // Second hit five cycles into the tone stretches it to 15 cycles.
      busy_cnt = 0;
      step("hit_restart", 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step("hit_restart", 1'b0, 1'b0, 1'b0, 1'b0);
      step("hit_restart", 1'b1, 1'b0, 1'b0, 1'b0);
      drain("hit_restart", 1'b0, 50);
      check("hit_restart_len", busy_cnt, 15);

      // Mute partway through the first note: silence, timing unchanged.
      busy_cnt = 0;
      step("mute", 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 30; i++) step("mute", 1'b0, 1'b0, 1'b0, (i >= 3 && i < 18));
      drain("mute", 1'b0, 100);
      check("mute_busy_len", busy_cnt, SCORE_LEN);

      // Asynchronous reset in the middle of a note.
      step("pre_async", 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step("pre_async", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      check("async_reset", 32'(dut_out()), 32'(RESET_VEC));
      bus.score_evt = 1'b1;
      @(posedge clk);
      #1;
      check("reset_score_dropped", 32'(dut_out()), 32'(RESET_VEC));
      @(negedge clk);
      bus.score_evt = 1'b0;
      rst           = 1'b1;
      model_reset();
      step("after_async", 1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic against the model.
      mute_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) mute_r = ~mute_r;
         step("random", $urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0,
              1'($urandom_range(0, 1)), mute_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Backstop against a hung run.
   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, expected normal end");
      $fatal(1, "watchdog expired");
   end

endmodule
